// File: rtl/board_pkg.sv
// Shared board geometry, cell encoding and drop-sequencer state type for the Connect-4 datapath.
// cell_addr() is the single definition of the row-major board address map.
package board_pkg;

  localparam int ROWS   = 6;
  localparam int COLS   = 7;
  localparam int CELL_W = 2;
  localparam int NCELLS = ROWS * COLS;
  localparam int ADDR_W = $clog2(NCELLS);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int COL_W  = $clog2(COLS);

  typedef enum logic [CELL_W-1:0] {
    CELL_EMPTY = 2'd0,
    CELL_P1    = 2'd1,
    CELL_P2    = 2'd2
  } cell_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_EVAL,
    ST_WRITE,
    ST_DONE,
    ST_REJECT,
    ST_CLEAR
  } drop_state_t;

  // Row 0 is the bottom row; the largest result is ROWS*COLS-1, which fits in ADDR_W bits.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
    return ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/board_drop_sequencer_if.sv
// Controller and board-RAM signals of the drop sequencer.
// The sequencer takes the slave view; the surrounding controller/RAM side takes the master view.
interface board_drop_sequencer_if;
  import board_pkg::*;

  logic                    start_drop;
  logic [COL_W-1:0]        drop_col;
  logic [CELL_W-1:0]       drop_player;
  logic                    start_clear;
  logic                    busy;
  logic                    done;
  logic                    col_full;
  logic                    error;
  logic [ROW_W-1:0]        placed_row;
  logic [COL_W-1:0]        placed_col;
  logic [ADDR_W-1:0]       mem_addr;
  logic                    mem_rd_en;
  logic [CELL_W-1:0]       mem_rd_data;
  logic                    mem_wr_en;
  logic [CELL_W-1:0]       mem_wr_data;

  modport slave (
    input  start_drop, drop_col, drop_player, start_clear, mem_rd_data,
    output busy, done, col_full, error, placed_row, placed_col,
           mem_addr, mem_rd_en, mem_wr_en, mem_wr_data
  );

  modport master (
    output start_drop, drop_col, drop_player, start_clear, mem_rd_data,
    input  busy, done, col_full, error, placed_row, placed_col,
           mem_addr, mem_rd_en, mem_wr_en, mem_wr_data
  );

endinterface

// File: rtl/board_drop_sequencer.sv
// Drop/clear sequencer for the single-port Connect-4 board RAM: bottom-up column scan,
// single write into the lowest empty cell, and a full-board clear sweep.
module board_drop_sequencer
  import board_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  board_drop_sequencer_if.slave  bus
);

  drop_state_t         r_state;
  logic [ROW_W-1:0]    r_row;
  logic [COL_W-1:0]    r_col;
  logic [CELL_W-1:0]   r_player;
  logic                r_done;
  logic                r_col_full;
  logic                r_error;
  logic [ROW_W-1:0]    r_placed_row;
  logic [COL_W-1:0]    r_placed_col;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_mem_rd_en;
  logic                r_mem_wr_en;
  logic [CELL_W-1:0]   r_mem_wr_data;

  logic w_drop_ok;
  logic w_last_row;
  logic w_last_addr;

  assign w_drop_ok   = (bus.drop_col < COL_W'(COLS)) &&
                       ((bus.drop_player == CELL_P1) || (bus.drop_player == CELL_P2));
  assign w_last_row  = (r_row == ROW_W'(ROWS - 1));
  assign w_last_addr = (r_mem_addr == ADDR_W'(NCELLS - 1));

  // NOTE: state and outputs are flops updated with <= only; the async reset clears every one of them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_row         <= '0;
      r_col         <= '0;
      r_player      <= '0;
      r_done        <= 1'b0;
      r_col_full    <= 1'b0;
      r_error       <= 1'b0;
      r_placed_row  <= '0;
      r_placed_col  <= '0;
      r_mem_addr    <= '0;
      r_mem_rd_en   <= 1'b0;
      r_mem_wr_en   <= 1'b0;
      r_mem_wr_data <= '0;
    end else begin
      // NOTE: strobes default low every cycle, so each branch only raises the ones it needs.
      r_done      <= 1'b0;
      r_col_full  <= 1'b0;
      r_error     <= 1'b0;
      r_mem_rd_en <= 1'b0;
      r_mem_wr_en <= 1'b0;

      if (bus.start_clear) begin
        // Clear wins from any state and always restarts the sweep at address 0.
        r_state       <= ST_CLEAR;
        r_row         <= '0;
        r_col         <= '0;
        r_mem_addr    <= '0;
        r_mem_wr_en   <= 1'b1;
        r_mem_wr_data <= CELL_EMPTY;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.start_drop) begin
              r_col    <= bus.drop_col;
              r_player <= bus.drop_player;
              r_row    <= '0;
              if (w_drop_ok) begin
                r_state     <= ST_RD_REQ;
                r_mem_rd_en <= 1'b1;
                r_mem_addr  <= cell_addr(ROW_W'(0), bus.drop_col);
              end else begin
                r_state <= ST_REJECT;
                r_done  <= 1'b1;
                r_error <= 1'b1;
              end
            end
          end

          ST_RD_REQ: r_state <= ST_EVAL;

          ST_EVAL: begin
            if (bus.mem_rd_data == CELL_EMPTY) begin
              r_state       <= ST_WRITE;
              r_mem_wr_en   <= 1'b1;
              r_mem_wr_data <= r_player;
            end else if (w_last_row) begin
              r_state    <= ST_REJECT;
              r_done     <= 1'b1;
              r_col_full <= 1'b1;
            end else begin
              r_state     <= ST_RD_REQ;
              r_row       <= r_row + 1'b1;
              r_mem_rd_en <= 1'b1;
              r_mem_addr  <= cell_addr(r_row + 1'b1, r_col);
            end
          end

          ST_WRITE: begin
            r_state      <= ST_DONE;
            r_done       <= 1'b1;
            r_placed_row <= r_row;
            r_placed_col <= r_col;
          end

          ST_DONE, ST_REJECT: r_state <= ST_IDLE;

          ST_CLEAR: begin
            if (w_last_addr) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_mem_addr  <= r_mem_addr + 1'b1;
              r_mem_wr_en <= 1'b1;
            end
          end

          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.done        = r_done;
  assign bus.col_full    = r_col_full;
  assign bus.error       = r_error;
  assign bus.placed_row  = r_placed_row;
  assign bus.placed_col  = r_placed_col;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_rd_en   = r_mem_rd_en;
  assign bus.mem_wr_en   = r_mem_wr_en;
  assign bus.mem_wr_data = r_mem_wr_data;

endmodule

// File: tb/tb_board_drop_sequencer.sv
// Scoreboard bench for board_drop_sequencer: directed drops/clears push expected RAM accesses
// and done pulses (with their edge numbers); a negedge monitor pops and compares them.
module tb_board_drop_sequencer;
  import board_pkg::*;

  typedef enum int {EV_READ, EV_WRITE, EV_DONE} ev_kind_e;

  typedef struct {
    ev_kind_e kind;
    int       at_edge;
    int       addr;
    int       data;
    int       col_full;
    int       error;
    int       row;
    int       col;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  ev_t  exp_q[$];

  board_drop_sequencer_if bus();

  board_drop_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Board RAM model: registered read, plus a bench-only preload/clear port.
  logic [CELL_W-1:0] mem [NCELLS];
  logic              pre_clr = 1'b0;
  logic              pre_we  = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [CELL_W-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_clr) begin
      for (int i = 0; i < NCELLS; i++) mem[i] <= '0;
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (bus.mem_wr_en) begin
      mem[bus.mem_addr] <= bus.mem_wr_data;
    end
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_ev(ev_kind_e k, int e, int a, int d, int cf, int er, int r, int c);
    ev_t ev;
    ev.kind = k; ev.at_edge = e; ev.addr = a; ev.data = d;
    ev.col_full = cf; ev.error = er; ev.row = r; ev.col = c;
    exp_q.push_back(ev);
  endfunction

  function automatic void exp_rd(int e, int a);
    push_ev(EV_READ, e, a, 0, 0, 0, 0, 0);
  endfunction

  function automatic void exp_wr(int e, int a, int d);
    push_ev(EV_WRITE, e, a, d, 0, 0, 0, 0);
  endfunction

  function automatic void exp_done(int e, int cf, int er, int r, int c);
    push_ev(EV_DONE, e, 0, 0, cf, er, r, c);
  endfunction

  function automatic void exp_clear(int k, int r, int c);
    for (int a = 0; a < NCELLS; a++) exp_wr(k + 1 + a, a, 0);
    exp_done(k + 43, 0, 0, r, c);
  endfunction

  task automatic compare_ev(input ev_kind_e k);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d addr %0d at edge %0d, expected no event",
               int'(k), bus.mem_addr, cyc + 1);
    end else begin
      e = exp_q.pop_front();
      check("ev_kind", int'(k), int'(e.kind));
      check("ev_edge", cyc + 1, e.at_edge);
      if (k == EV_DONE) begin
        check("done_col_full", int'(bus.col_full), e.col_full);
        check("done_error", int'(bus.error), e.error);
        check("placed_row", int'(bus.placed_row), e.row);
        check("placed_col", int'(bus.placed_col), e.col);
      end else begin
        check("mem_addr", int'(bus.mem_addr), e.addr);
        if (k == EV_WRITE) check("mem_wr_data", int'(bus.mem_wr_data), e.data);
      end
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, so an event seen now lands on edge cyc+1.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.mem_rd_en && bus.mem_wr_en) check("rd_wr_exclusive", 1, 0);
      if (bus.mem_rd_en) compare_ev(EV_READ);
      if (bus.mem_wr_en) compare_ev(EV_WRITE);
      if (bus.done) compare_ev(EV_DONE);
    end
  end

  task automatic start_op(input bit drop, input bit clr, input int col, input int player,
                          output int k);
    @(negedge clk);
    k = cyc + 1;
    bus.start_drop  = drop;
    bus.start_clear = clr;
    bus.drop_col    = COL_W'(col);
    bus.drop_player = CELL_W'(player);
  endtask

  task automatic end_op();
    @(negedge clk);
    bus.start_drop  = 1'b0;
    bus.start_clear = 1'b0;
  endtask

  task automatic poke(input int a, input int d);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = ADDR_W'(a);
    pre_data = CELL_W'(d);
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !bus.busy) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d events pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},       int'(bus.busy), 0);
    check({tag, "_done"},       int'(bus.done), 0);
    check({tag, "_col_full"},   int'(bus.col_full), 0);
    check({tag, "_error"},      int'(bus.error), 0);
    check({tag, "_placed_row"}, int'(bus.placed_row), 0);
    check({tag, "_placed_col"}, int'(bus.placed_col), 0);
    check({tag, "_mem_addr"},   int'(bus.mem_addr), 0);
    check({tag, "_mem_rd_en"},  int'(bus.mem_rd_en), 0);
    check({tag, "_mem_wr_en"},  int'(bus.mem_wr_en), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    int nz;
    bus.start_drop  = 1'b0;
    bus.start_clear = 1'b0;
    bus.drop_col    = '0;
    bus.drop_player = '0;

    // Reset state, then empty the RAM model before releasing reset.
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    pre_clr = 1'b1;
    @(negedge clk);
    pre_clr = 1'b0;
    rst = 1'b1;

    // Empty column 3, player 1.
    start_op(1, 0, 3, 1, k);
    exp_rd(k + 1, 3);
    exp_wr(k + 3, 3, 1);
    exp_done(k + 4, 0, 0, 0, 3);
    end_op();
    wait_idle(20, "drop_empty");

    // Column 3 holds P1,P2 in rows 0,1; player 2 lands in row 2.
    poke(10, 2);
    start_op(1, 0, 3, 2, k);
    exp_rd(k + 1, 3);
    exp_rd(k + 3, 10);
    exp_rd(k + 5, 17);
    exp_wr(k + 7, 17, 2);
    exp_done(k + 8, 0, 0, 2, 3);
    end_op();
    wait_idle(30, "drop_stack");

    // Full column 6: six reads, no write, col_full, placed_* unchanged.
    for (int r = 0; r < ROWS; r++) poke(6 + 7 * r, (r % 2) + 1);
    start_op(1, 0, 6, 1, k);
    for (int r = 0; r < ROWS; r++) exp_rd(k + 1 + 2 * r, 6 + 7 * r);
    exp_done(k + 13, 1, 0, 2, 3);
    end_op();
    wait_idle(40, "drop_full");

    // Invalid requests: bad column, then bad player values.
    start_op(1, 0, 7, 1, k);
    exp_done(k + 1, 0, 1, 2, 3);
    end_op();
    wait_idle(10, "bad_col");
    start_op(1, 0, 2, 3, k);
    exp_done(k + 1, 0, 1, 2, 3);
    end_op();
    wait_idle(10, "bad_player3");
    start_op(1, 0, 0, 0, k);
    exp_done(k + 1, 0, 1, 2, 3);
    end_op();
    wait_idle(10, "bad_player0");

    // Full clear with a drop issued mid-sweep that must be ignored.
    start_op(0, 1, 0, 0, k);
    exp_clear(k, 2, 3);
    end_op();
    repeat (10) @(negedge clk);
    check("busy_mid_clear", int'(bus.busy), 1);
    start_op(1, 0, 5, 1, k);
    end_op();
    wait_idle(100, "clear");
    nz = 0;
    for (int a = 0; a < NCELLS; a++) if (mem[a] != '0) nz++;
    check("board_cleared", nz, 0);

    // Clear aborts a drop while it evaluates row 1 of a column with 3 occupied cells.
    poke(1, 1);
    poke(8, 1);
    poke(15, 1);
    start_op(1, 0, 1, 2, k);
    exp_rd(k + 1, 1);
    exp_rd(k + 3, 8);
    end_op();
    while (cyc < k + 3) @(negedge clk);
    bus.start_clear = 1'b1;
    exp_clear(k + 4, 2, 3);
    @(negedge clk);
    bus.start_clear = 1'b0;
    wait_idle(100, "abort_clear");

    // Simultaneous drop and clear: clear wins, drop discarded.
    start_op(1, 1, 0, 1, k);
    exp_clear(k, 2, 3);
    end_op();
    wait_idle(100, "sim_clear");

    // Async reset during a scan, then a normal drop.
    poke(4, 1);
    poke(11, 2);
    start_op(1, 0, 4, 1, k);
    exp_rd(k + 1, 4);
    end_op();
    while (cyc < k + 1) @(negedge clk);
    rst = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    check("async_rst_queue", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    start_op(1, 0, 4, 1, k);
    exp_rd(k + 1, 4);
    exp_rd(k + 3, 11);
    exp_rd(k + 5, 18);
    exp_wr(k + 7, 18, 1);
    exp_done(k + 8, 0, 0, 2, 4);
    end_op();
    wait_idle(30, "post_rst_drop");
    check("post_rst_mem18", int'(mem[18]), 1);

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/board_drop_sequencer.md
Name: board_drop_sequencer

Overview:
Sequences the single-port board memory for the Connect-4 game. On a drop request it scans the chosen column bottom-up, writes the player's piece into the lowest empty cell, and reports the landing row. It also performs a full-board clear.
It sits between the game controller (whose insert-piece and reset-board strobes drive start_drop/start_clear) and the board RAM. The win checker and renderer read the board only while busy=0.

Parameters:
ROWS, 6, board rows; row 0 is the bottom row.
COLS, 7, board columns.
CELL_W, 2, bits per cell; 0=empty, 1=player 1, 2=player 2, 3=illegal.
ADDR_W, 6, memory address width; equals $clog2(ROWS*COLS).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start_drop  in  1  one-cycle request to drop a piece
drop_col  in  3  target column 0..COLS-1, sampled with start_drop
drop_player  in  2  piece value 1 or 2, sampled with start_drop
start_clear  in  1  one-cycle request to clear the whole board
busy  out  1  high while any operation is in progress
done  out  1  one-cycle completion pulse (drop, reject or clear)
col_full  out  1  qualifies done: the column had no empty cell
error  out  1  qualifies done: bad column or bad player value
placed_row  out  3  landing row of the last successful drop
placed_col  out  3  column of the last successful drop
mem_addr  out  ADDR_W  cell address = row*COLS + col
mem_rd_en  out  1  read strobe; data is valid on the following cycle
mem_rd_data  in  CELL_W  read data
mem_wr_en  out  1  write strobe
mem_wr_data  out  CELL_W  write data

Behaviour:
- Reset values: state IDLE; all outputs 0, including placed_row/placed_col and mem_addr.
- States: IDLE, RD_REQ, EVAL, WRITE, DONE, REJECT, CLEAR.
- IDLE:
  - start_clear takes priority over start_drop when both are high; either leads to CLEAR with row/col counters = 0.
  - start_drop alone latches col and player.
    - col >= COLS or player not in {1,2}: go to REJECT.
    - Otherwise go to RD_REQ with row = 0.
- RD_REQ: mem_rd_en=1, mem_addr = row*COLS + col; go to EVAL.
- EVAL: examine mem_rd_data.
  - Value 0: go to WRITE.
  - Nonzero and row = ROWS-1: go to REJECT with col_full set.
  - Nonzero otherwise: row+1, back to RD_REQ.
- WRITE: mem_wr_en=1, mem_addr = row*COLS + col, mem_wr_data = player. placed_row/placed_col update at the end of this cycle. Go to DONE.
- DONE: done=1 for one cycle; go to IDLE.
- REJECT: done=1 plus col_full or error for one cycle. No memory write, placed_* unchanged. Go to IDLE.
- CLEAR: one write of 0 per cycle to addresses 0..ROWS*COLS-1, in ascending order. After the last address go to DONE.
- busy=1 in every state except IDLE.
- Latency, with start sampled at edge k:
  - Empty column: write at k+3, done at k+4.
  - n occupied cells: done at k+4+2n.
  - Full column: done+col_full at k+13.
  - Invalid request: done+error at k+1.
  - Clear: writes at k+1..k+42, done at k+43.
- start_drop while busy: ignored, no queuing.
- start_clear while busy: aborts any drop in progress, with no done for the aborted drop and no write if WRITE has not yet occurred. The next cycle restarts CLEAR from address 0, including when a CLEAR is already running.
- mem_rd_en and mem_wr_en are never high in the same cycle.
- mem_addr holds its last value when no strobe is active.
- Address arithmetic is done at ADDR_W bits with no overflow; max address is 41.
- Asynchronous reset mid-operation: immediate return to IDLE with all outputs 0. The memory content is left as-is.

Decomposition:
- Package board_pkg holds:
  - ROWS, COLS, ADDR_W and CELL_W constants.
  - cell_t enum: CELL_EMPTY=0, CELL_P1=1, CELL_P2=2.
  - The drop_state_t enum.
- No sub-module is needed. The address multiply-add is a small combinational function in board_pkg (cell_addr(row,col)), shared with the win checker and renderer.
- The board RAM is external.

Test Plan:
- Empty board; drop col 3, player 1 at edge k → one read at addr 3, one write addr 3 data 1 at k+3, done at k+4, placed_row=0, placed_col=3.
- Col 3 holding P1,P2 in rows 0,1; drop col 3, player 2 → reads addr 3, 10, 17; write addr 17 data 2; done at k+8; placed_row=2.
- Col 6 fully occupied → six reads (addr 6..41 step 7), no write, done+col_full at k+13, placed_* unchanged.
- drop_col=7, then drop_col=2 with player 3 → each gives done+error at k+1 and no memory access.
- start_clear → 42 writes of 0 to addr 0..41 on consecutive cycles, done at k+43; a start_drop issued mid-clear is ignored.
- Drop in progress (column with 3 occupied cells), start_clear at EVAL of row 1 → no write to column, no drop done, clear completes with a single done.
- Simultaneous start_drop and start_clear in IDLE → clear runs, drop discarded.
- rst asserted mid-scan → outputs 0 immediately; the next drop after release behaves normally.
